// File: rtl/if_cfg_loader_if.sv
// if_cfg_loader_if: handshake/bus bundle around the configuration loader.
//   Interface-block side : IFCFG, IFCFG_Val, IF_RdDone (in), CFG_Req (out)
//   Layer-controller side: Layer_Start (in), CFG_Data, CFG_Val, CFG_Busy,
//                          CFG_Err (out)
// Modports: slave = the loader itself, master = its environment.
`ifndef PORT_DATAWIDTH
`define PORT_DATAWIDTH 128
`endif

interface if_cfg_loader_if #(
  parameter int DATA_WIDTH = `PORT_DATAWIDTH,
  parameter int CFG_WORDS  = 4
);
  logic                            Layer_Start;
  logic                            CFG_Req;
  logic [DATA_WIDTH-1:0]           IFCFG;
  logic                            IFCFG_Val;
  logic                            IF_RdDone;
  logic [DATA_WIDTH*CFG_WORDS-1:0] CFG_Data;
  logic                            CFG_Val;
  logic                            CFG_Busy;
  logic                            CFG_Err;

  modport slave (
    input  Layer_Start, IFCFG, IFCFG_Val, IF_RdDone,
    output CFG_Req, CFG_Data, CFG_Val, CFG_Busy, CFG_Err
  );

  modport master (
    output Layer_Start, IFCFG, IFCFG_Val, IF_RdDone,
    input  CFG_Req, CFG_Data, CFG_Val, CFG_Busy, CFG_Err
  );
endinterface

// File: rtl/if_cfg_loader.sv
// if_cfg_loader: requests a layer configuration burst, collects CFG_WORDS
// words into a staging register and commits them atomically to CFG_Data.
// Short bursts (IF_RdDone before the last word) and unsolicited words set the
// sticky CFG_Err; the committed configuration is never touched by them.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   Reset  - synchronous soft clear, highest priority
//   bus    - if_cfg_loader_if.slave (request/word stream/committed config)
// Optional build macro: CFG_TIMEOUT_EN enables an idle-word watchdog that
// aborts RECV after TIMEOUT_CYCLES consecutive cycles without a word.
`ifndef PORT_DATAWIDTH
`define PORT_DATAWIDTH 128
`endif

module if_cfg_loader #(
  parameter int DATA_WIDTH     = `PORT_DATAWIDTH,
  parameter int CFG_WORDS      = 4,
  parameter int CNT_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           Reset,
  if_cfg_loader_if.slave bus
);

  localparam int IDXW = $clog2(CFG_WORDS);

  if (CFG_WORDS < 2 || CFG_WORDS >= (1 << CNT_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("if_cfg_loader: inconsistent CFG_WORDS/CNT_WIDTH/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;

  state_t                               state_q;
  logic [CNT_WIDTH-1:0]                 cnt_q;
  logic [CFG_WORDS-1:0][DATA_WIDTH-1:0] stage_q;
  logic [CFG_WORDS-1:0][DATA_WIDTH-1:0] data_q;
  logic                                 req_q;
  logic                                 val_q;
  logic                                 err_q;

`ifdef CFG_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q;
`endif

  logic last_word;
  assign last_word = bus.IFCFG_Val && (cnt_q == CNT_WIDTH'(CFG_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef CFG_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef CFG_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      // Pulse outputs default low; they are raised only on the edge that
      // enters the cycle in which they must be seen.
      req_q <= 1'b0;
      val_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Layer_Start) begin
            state_q <= REQ;
            req_q   <= 1'b1;   // Moore CFG_Req: high exactly during REQ
          end
          // An unsolicited word wins over the error clear of a coincident start.
          if (bus.IFCFG_Val)        err_q <= 1'b1;
          else if (bus.Layer_Start) err_q <= 1'b0;
        end
        REQ: begin
          state_q <= RECV;
`ifdef CFG_TIMEOUT_EN
          wd_q    <= '0;
`endif
          if (bus.IFCFG_Val) begin
            stage_q[0] <= bus.IFCFG;
            cnt_q      <= CNT_WIDTH'(1);
          end
        end
        RECV: begin
`ifdef CFG_TIMEOUT_EN
          wd_q <= bus.IFCFG_Val ? '0 : wd_q + 1'b1;
`endif
          if (last_word) begin
            // Commit the staged words together with the one arriving now.
            data_q  <= {bus.IFCFG, stage_q[CFG_WORDS-2:0]};
            val_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (bus.IF_RdDone) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef CFG_TIMEOUT_EN
          end else if (!bus.IFCFG_Val && wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
`endif
          end else if (bus.IFCFG_Val) begin
            stage_q[cnt_q[IDXW-1:0]] <= bus.IFCFG;
            cnt_q                    <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.CFG_Req  = req_q;
  assign bus.CFG_Val  = val_q;
  assign bus.CFG_Err  = err_q;
  assign bus.CFG_Data = data_q;
  assign bus.CFG_Busy = (state_q != IDLE);

endmodule

// File: tb/tb_if_cfg_loader.sv
// tb_if_cfg_loader: directed bench for if_cfg_loader. A queue-based model of
// the load protocol predicts every output each cycle; literal checks pin the
// model at the key points of each scenario.
module tb_if_cfg_loader;
  localparam int DW = 128;
  localparam int W  = 4;
  localparam int TO = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic Reset = 1'b0;

  if_cfg_loader_if #(.DATA_WIDTH(DW), .CFG_WORDS(W)) bus ();

  if_cfg_loader #(
    .DATA_WIDTH(DW), .CFG_WORDS(W), .CNT_WIDTH(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Reset(Reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int req_pulses = 0;

  task automatic chk(input string name, input logic [W*DW-1:0] got, input logic [W*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [DW-1:0]   q[$];
  bit              m_busy = 0, m_req = 0, m_val = 0, m_err = 0;
  logic [W*DW-1:0] m_data = '0;
  int              m_idle = 0;

  task automatic m_clear();
    q.delete();
    m_busy = 0; m_req = 0; m_val = 0; m_err = 0; m_data = '0; m_idle = 0;
  endtask

  always @(negedge rst_n) m_clear();

  always @(posedge clk) begin : mdl
    bit was_req;
    if (bus.CFG_Req === 1'b1) req_pulses++;
    if (!rst_n || Reset) m_clear();
    else begin
      was_req = m_req;
      m_req = 0;
      m_val = 0;
      if (!m_busy) begin
        if (bus.Layer_Start) begin
          m_busy = 1; m_req = 1; q.delete(); m_idle = 0;
        end
        if (bus.IFCFG_Val)        m_err = 1;
        else if (bus.Layer_Start) m_err = 0;
      end else begin
        if (bus.IFCFG_Val) begin
          q.push_back(bus.IFCFG);
          m_idle = 0;
        end else if (!was_req) m_idle++;
        if (q.size() == W) begin
          for (int i = 0; i < W; i++) m_data[i*DW +: DW] = q[i];
          m_val = 1; m_busy = 0;
        end else if (!was_req && bus.IF_RdDone) begin
          m_err = 1; m_busy = 0;
        end
`ifdef CFG_TIMEOUT_EN
        else if (!was_req && m_idle >= TO) begin
          m_err = 1; m_busy = 0;
        end
`endif
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_req",  bus.CFG_Req,  m_req);
    chk("cyc_val",  bus.CFG_Val,  m_val);
    chk("cyc_busy", bus.CFG_Busy, m_busy);
    chk("cyc_err",  bus.CFG_Err,  m_err);
    chk("cyc_data", bus.CFG_Data, m_data);
  end

  // ---------------- stimulus ----------------
  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction

  task automatic cyc(input bit st, input bit v, input logic [DW-1:0] w, input bit dn);
    @(negedge clk);
    bus.Layer_Start = st;
    bus.IFCFG_Val   = v;
    bus.IFCFG       = v ? w : '0;
    bus.IF_RdDone   = dn;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, '0, 0);
  endtask

  // Start + four back-to-back words (word 0 lands in the REQ cycle).
  task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    cyc(1, 0, '0, 0);
    cyc(0, 1, rep(a), 0);
    cyc(0, 1, rep(b), 0);
    cyc(0, 1, rep(c), 0);
    cyc(0, 1, rep(d), 0);
  endtask

  logic [W*DW-1:0] d1, d2, d3, d4, d5;
  int p0;

  initial begin
    bus.Layer_Start = 0; bus.IFCFG_Val = 0; bus.IFCFG = '0; bus.IF_RdDone = 0;
    d1 = {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)};
    d2 = {rep(8'hD4), rep(8'hC3), rep(8'hB2), rep(8'hA1)};
    d3 = {rep(8'h58), rep(8'h57), rep(8'h56), rep(8'h55)};
    d4 = {rep(8'h6D), rep(8'h6C), rep(8'h6B), rep(8'h6A)};
    d5 = {rep(8'h7F), rep(8'h7E), rep(8'h7D), rep(8'h7C)};

    repeat (2) @(negedge clk);
    chk("rst_data", bus.CFG_Data, '0);
    chk("rst_err",  bus.CFG_Err,  0);
    chk("rst_busy", bus.CFG_Busy, 0);
    rst_n = 1'b1;

    // 1: basic load
    p0 = req_pulses;
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    idle(1);
    chk("t1_val",  bus.CFG_Val, 1);
    chk("t1_data", bus.CFG_Data, d1);
    chk("t1_err",  bus.CFG_Err, 0);
    chk("t1_req_pulses", req_pulses - p0, 1);
    idle(1);
    chk("t1_val_one_cycle", bus.CFG_Val, 0);

    // 2: gapped words, IF_RdDone with the last word
    cyc(1, 0, '0, 0);
    idle(2);
    cyc(0, 1, rep(8'hA1), 0);
    cyc(0, 1, rep(8'hB2), 0);
    idle(5);
    cyc(0, 1, rep(8'hC3), 0);
    idle(3);
    cyc(0, 1, rep(8'hD4), 1);
    idle(1);
    chk("t2_val",  bus.CFG_Val, 1);
    chk("t2_data", bus.CFG_Data, d2);
    chk("t2_err",  bus.CFG_Err, 0);
    idle(2);

    // 3: short burst then recovery
    cyc(1, 0, '0, 0);
    cyc(0, 1, rep(8'hE0), 0);
    cyc(0, 1, rep(8'hE1), 0);
    cyc(0, 0, '0, 1);
    idle(1);
    chk("t3_err",  bus.CFG_Err, 1);
    chk("t3_busy", bus.CFG_Busy, 0);
    chk("t3_data_kept", bus.CFG_Data, d2);
    cyc(1, 0, '0, 0);
    cyc(0, 1, rep(8'h55), 0);
    chk("t3_err_cleared", bus.CFG_Err, 0);
    cyc(0, 1, rep(8'h56), 0);
    cyc(0, 1, rep(8'h57), 0);
    cyc(0, 1, rep(8'h58), 0);
    idle(1);
    chk("t3_reload", bus.CFG_Data, d3);

    // 4: unsolicited word, start during RECV, extra word after completion
    cyc(0, 1, rep(8'hEE), 0);
    idle(1);
    chk("t4_unsolicited_err", bus.CFG_Err, 1);
    chk("t4_data_kept", bus.CFG_Data, d3);
    p0 = req_pulses;
    cyc(1, 0, '0, 0);
    cyc(0, 1, rep(8'h6A), 0);
    cyc(1, 1, rep(8'h6B), 0);
    cyc(1, 1, rep(8'h6C), 0);
    cyc(0, 1, rep(8'h6D), 0);
    cyc(0, 1, rep(8'hFF), 0);
    chk("t4_val", bus.CFG_Val, 1);
    idle(1);
    chk("t4_extra_err", bus.CFG_Err, 1);
    chk("t4_data", bus.CFG_Data, d4);
    chk("t4_req_pulses", req_pulses - p0, 1);

    // 5a: synchronous Reset mid-burst
    cyc(1, 0, '0, 0);
    cyc(0, 1, rep(8'h90), 0);
    cyc(0, 1, rep(8'h91), 0);
    @(negedge clk);
    bus.IFCFG_Val = 0; bus.IFCFG = '0; Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("t5_sync_data", bus.CFG_Data, '0);
    chk("t5_sync_busy", bus.CFG_Busy, 0);
    chk("t5_sync_err",  bus.CFG_Err, 0);
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    idle(1);
    chk("t5_sync_reload", bus.CFG_Data, d1);

    // 5b: asynchronous rst_n mid-cycle, mid-burst
    cyc(1, 0, '0, 0);
    cyc(0, 1, rep(8'h92), 0);
    cyc(0, 1, rep(8'h93), 0);
    @(negedge clk);
    bus.IFCFG_Val = 0; bus.IFCFG = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_data", bus.CFG_Data, '0);
    chk("t5_async_busy", bus.CFG_Busy, 0);
    #1 rst_n = 1'b1;
    load4(8'h7C, 8'h7D, 8'h7E, 8'h7F);
    idle(1);
    chk("t5_async_reload", bus.CFG_Data, d5);
    chk("t5_async_val", bus.CFG_Val, 1);

    // 6: one word then silence
    cyc(1, 0, '0, 0);
    cyc(0, 1, rep(8'hAB), 0);
    idle(TO + 10);
`ifdef CFG_TIMEOUT_EN
    chk("t6_timeout_err",  bus.CFG_Err, 1);
    chk("t6_timeout_busy", bus.CFG_Busy, 0);
`else
    chk("t6_wait_busy", bus.CFG_Busy, 1);
    chk("t6_wait_err",  bus.CFG_Err, 0);
`endif
    chk("t6_data_kept", bus.CFG_Data, d5);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("t6_cleared_busy", bus.CFG_Busy, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
